sfu_array: RTL and testbench

Multi-lane special-function unit placed after the systolic array's psum outputs. It accumulates signed partial sums per column across a frame of beats delimited by an explicit last marker. It then applies a selectable activation with saturation and presents the result through a valid/ready output handshake. It is the successor of the single-lane ReLU SFU, generalised in lane count, accumulator width and activation mode, with backpressure.

---
 rtl/sfu_pkg.sv | 15 +
 rtl/sfu_lane.sv | 56 +++++
 rtl/sfu_array.sv | 66 ++++++
 tb/tb_sfu_array.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared constants for the multi-lane special-function unit: activation modes,
// FSM state encoding and the leaky-ReLU shift amount.
package sfu_pkg;

  localparam logic [1:0] SFU_RELU  = 2'b00;
  localparam logic [1:0] SFU_PASS  = 2'b01;
  localparam logic [1:0] SFU_LEAKY = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/sfu_lane.sv
// One column: wrapping accumulator, clamp to psum range, then activation into
// a registered output captured on the frame's last beat.
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_en,
  input  logic               first,
  input  logic               last,
  input  logic               clr,
  input  logic [1:0]         mode,
  input  logic [psum_bw-1:0] psum_in,
  output logic [psum_bw-1:0] psum_out
);

  localparam logic signed [acc_bw-1:0] SAT_MAX =
    {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] SAT_MIN =
    {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  logic signed [acc_bw-1:0]  acc, acc_nxt, ext;
  logic signed [psum_bw-1:0] sat_v, act_v;

  assign ext = acc_bw'($signed(psum_in));
  // First beat restarts from the beat itself, independent of the clear.
  assign acc_nxt = (first ? '0 : acc) + ext;

  always_comb begin
    sat_v = acc_nxt[psum_bw-1:0];
    if (acc_nxt > SAT_MAX)      sat_v = SAT_MAX[psum_bw-1:0];
    else if (acc_nxt < SAT_MIN) sat_v = SAT_MIN[psum_bw-1:0];
    act_v = sat_v;
    case (mode)
      SFU_RELU:  if (sat_v[psum_bw-1]) act_v = '0;
      SFU_LEAKY: if (sat_v[psum_bw-1]) act_v = sat_v >>> LEAKY_SHIFT;
      default:   act_v = sat_v;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      psum_out <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc_nxt;
      if (last) psum_out <= act_v;
    end
  end

endmodule

// File: rtl/sfu_array.sv
// Multi-lane SFU: frame FSM, input/output handshake and mode latch shared by
// col instances of sfu_lane.
module sfu_array
  import sfu_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   valid_in,
  input  logic                   last_in,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   in_ready,
  output logic [col*psum_bw-1:0] psum_out,
  output logic                   valid_out,
  input  logic                   out_ready,
  output logic                   busy
);

  logic [1:0] state, mode_q, eff_mode;
  logic       acc_en, first, clr;

  assign in_ready  = (state != ST_OUT);
  assign valid_out = (state == ST_OUT);
  assign busy      = (state == ST_ACC) || (state == ST_OUT);
  assign acc_en    = valid_in && in_ready;
  assign first     = (state == ST_IDLE);
  assign clr       = (state == ST_OUT) && out_ready;
  // A single-beat frame must see the live mode, not last frame's latch.
  assign eff_mode  = first ? mode : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= SFU_RELU;
    end else begin
      case (state)
        ST_IDLE: if (acc_en) begin
          mode_q <= mode;
          state  <= last_in ? ST_OUT : ST_ACC;
        end
        ST_ACC:  if (acc_en && last_in) state <= ST_OUT;
        ST_OUT:  if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfu_lane #(.psum_bw(psum_bw), .acc_bw(acc_bw)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .acc_en  (acc_en),
      .first   (first),
      .last    (last_in),
      .clr     (clr),
      .mode    (eff_mode),
      .psum_in (psum_in[i*psum_bw +: psum_bw]),
      .psum_out(psum_out[i*psum_bw +: psum_bw])
    );
  end

endmodule

// File: tb/tb_sfu_array.sv
// Scoreboard bench for sfu_array (4 lanes): directed frames plus random frames
// checked against an integer reference model.
`timescale 1ns/1ps
module tb_sfu_array;

  localparam int COL = 4;
  localparam int PBW = 16;
  localparam int ABW = 24;

  logic                   clk = 0;
  logic                   reset = 1;
  logic [1:0]             mode = 0;
  logic                   valid_in = 0;
  logic                   last_in = 0;
  logic [COL*PBW-1:0]     psum_in = '0;
  logic                   in_ready;
  logic [COL*PBW-1:0]     psum_out;
  logic                   valid_out;
  logic                   out_ready = 1;
  logic                   busy;

  sfu_array #(.col(COL), .psum_bw(PBW), .acc_bw(ABW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .valid_in(valid_in),
    .last_in(last_in), .psum_in(psum_in), .in_ready(in_ready),
    .psum_out(psum_out), .valid_out(valid_out), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [COL*PBW-1:0] exp_q[$];
  bit rand_or = 0;

  // reference model state
  int       m_sum[COL];
  int       m_mode;
  bit       m_in_frame = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wrap_acc(input int v);
    int r;
    r = v % (1 << ABW);
    if (r >= (1 << (ABW-1)))  r -= (1 << ABW);
    if (r < -(1 << (ABW-1))) r += (1 << ABW);
    return r;
  endfunction

  function automatic int activate(input int s, input int md);
    int v;
    v = s;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    if (md == 0 && v < 0) v = 0;
    if (md == 2 && v < 0) v = -((-v + 7) / 8);  // floor(v/8)
    return v;
  endfunction

  function automatic logic [COL*PBW-1:0] pack(input int v[COL]);
    logic [COL*PBW-1:0] p;
    logic [PBW-1:0] t;
    p = '0;
    for (int i = 0; i < COL; i++) begin
      t = PBW'(v[i]);
      p[i*PBW +: PBW] = t;
    end
    return p;
  endfunction

  function automatic void model_beat(input int v[COL], input bit last, input int md);
    int r[COL];
    if (!m_in_frame) begin
      m_mode = md;
      for (int i = 0; i < COL; i++) m_sum[i] = 0;
      m_in_frame = 1;
    end
    for (int i = 0; i < COL; i++) m_sum[i] = wrap_acc(m_sum[i] + v[i]);
    if (last) begin
      for (int i = 0; i < COL; i++) r[i] = activate(m_sum[i], m_mode);
      exp_q.push_back(pack(r));
      m_in_frame = 0;
    end
  endfunction

  // Present one beat and hold it until accepted; model updates on acceptance.
  task automatic send_beat(input int v[COL], input bit last, input int md);
    bit done;
    done = 0;
    valid_in = 1; last_in = last; mode = 2'(md); psum_in = pack(v);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        model_beat(v, last, md);
      end
      @(posedge clk); #1;
    end
    valid_in = 0; last_in = 0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: beat never accepted");
    end else if (last) begin
      check("valid_latency", {63'd0, valid_out}, 64'd1);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1; valid_in = 0; last_in = 0;
    @(posedge clk); #1;
    check("rst_valid_out", {63'd0, valid_out}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_psum_out",  64'(psum_out),      64'd0);
    exp_q.delete();
    m_in_frame = 0;
    reset = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !valid_out) ok = 1;
    end
    check("drain", {63'd0, ok}, 64'd1);
  endtask

  // Monitor: pop on handshake, and hold outputs steady while stalled.
  logic [COL*PBW-1:0] prev_out;
  bit prev_stall = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) check("stall_hold", 64'(psum_out), 64'(prev_out));
        if (valid_out && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: got %h expected none", psum_out);
          end else begin
            check("psum_out", 64'(psum_out), 64'(exp_q.pop_front()));
          end
        end
        prev_stall = valid_out && !out_ready;
        prev_out   = psum_out;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v[COL];
    do_reset();

    // ReLU multi-beat on lane 0
    for (int b = 1; b <= 5; b++) begin
      v = '{b, 0, 0, 0};
      send_beat(v, b == 5, 0);
      if (b == 1) check("busy_acc", {63'd0, busy}, 64'd1);
    end
    drain();

    // Negative frame under each mode (3 = reserved -> passthrough)
    for (int md = 0; md < 4; md++) begin
      v = '{0, -3, 0, 0}; send_beat(v, 0, md);
      v = '{0,  1, 0, 0}; send_beat(v, 1, md);
      drain();
    end

    // Saturation both ways
    v = '{0, 0, 30000, -30000}; send_beat(v, 0, 1);
    v = '{0, 0, 30000, -30000}; send_beat(v, 1, 1);
    drain();

    // Backpressure: stalled output, new beat held upstream
    out_ready = 0;
    v = '{100, -200, 300, -400}; send_beat(v, 1, 1);
    v = '{9, 8, 7, 6};
    valid_in = 1; last_in = 1; psum_in = pack(v); mode = 2'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_busy",     {63'd0, busy},     64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send_beat(v, 1, 1);
    drain();

    // Gaps plus mid-frame mode change: ReLU stays latched
    v = '{2, 0, 0, 0};  send_beat(v, 0, 0);
    idle_cycles(3);
    v = '{-5, 0, 0, 0}; send_beat(v, 1, 1);
    drain();

    // Reset mid-frame discards partial sums
    v = '{7, 0, 0, 0}; send_beat(v, 0, 1);
    v = '{7, 0, 0, 0}; send_beat(v, 0, 1);
    do_reset();
    v = '{4, 0, 0, 0}; send_beat(v, 1, 1);
    drain();

    // Random frames with random backpressure and gaps
    rand_or = 1;
    for (int f = 0; f < 40; f++) begin
      int len, md;
      len = $urandom_range(1, 6);
      md  = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < COL; i++)
          v[i] = $urandom_range(0, 1) ? int'($signed(16'($urandom))) :
                                        $urandom_range(0, 40) - 20;
        send_beat(v, b == len - 1, (b == 0) ? md : int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end
    end
    rand_or = 0;
    @(posedge clk); #1;
    out_ready = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
